// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_pkg
//  Description : Shared constants and state encoding for the OV7670
//                register-configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

    // ROM entry markers: only these exact words are interpreted
    localparam logic [15:0] OV7670_ROM_END   = 16'hFF_FF;
    localparam logic [15:0] OV7670_ROM_DELAY = 16'hFF_F0;

    // SCCB 8-bit write ID of the OV7670
    localparam logic [7:0]  OV7670_SCCB_WR_ID = 8'h42;

    // Retry counter width (MAX_RETRY is limited to 0..15)
    localparam int C_RETRY_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_WAIT_ROM  = 4'd2,
        ST_DECODE    = 4'd3,
        ST_SEND      = 4'd4,
        ST_WAIT_XFER = 4'd5,
        ST_DELAY     = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ov7670_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_config_sequencer
//  Description : Walks the OV7670 config ROM from address 0, issuing one
//                SCCB write per {reg,val} entry. Handles delay/end markers,
//                retries NACKed writes, reports done/error.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_dout,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic [7:0]        o_cmd_reg,
    output logic [7:0]        o_cmd_val,
    input  logic              i_xfer_done,
    input  logic              i_xfer_nack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ROM_AW-1:0] o_err_addr
);

    localparam int                    C_DLY_W     = $clog2(DELAY_CYCLES + 1);
    localparam logic [C_DLY_W-1:0]    C_DLY_LOAD  = C_DLY_W'(DELAY_CYCLES - 1);
    localparam logic [ROM_AW-1:0]     C_LAST_ADDR = {ROM_AW{1'b1}};
    localparam logic [C_RETRY_W-1:0]  C_MAX_RETRY = C_RETRY_W'(MAX_RETRY);

    seq_state_t             r_state,    w_state;
    logic [ROM_AW-1:0]      r_addr,     w_addr;
    logic                   r_valid,    w_valid;
    logic [7:0]             r_reg,      w_reg;
    logic [7:0]             r_val,      w_val;
    logic                   r_busy,     w_busy;
    logic                   r_done,     w_done;
    logic                   r_error,    w_error;
    logic [ROM_AW-1:0]      r_err_addr, w_err_addr;
    logic [C_DLY_W-1:0]     r_dly,      w_dly;
    logic [C_RETRY_W-1:0]   r_retry,    w_retry;
    logic                   w_advance;

    // State and datapath registers; reset aborts any sequence immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_reg      <= '0;
            r_val      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_dly      <= '0;
            r_retry    <= '0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_valid    <= w_valid;
            r_reg      <= w_reg;
            r_val      <= w_val;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
            r_err_addr <= w_err_addr;
            r_dly      <= w_dly;
            r_retry    <= w_retry;
        end
    end

    // Next-state logic; "advance" is shared by the ACKed-write and delay exits
    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_valid    = r_valid;
        w_reg      = r_reg;
        w_val      = r_val;
        w_busy     = r_busy;
        w_done     = r_done;
        w_error    = r_error;
        w_err_addr = r_err_addr;
        w_dly      = r_dly;
        w_retry    = r_retry;
        w_advance  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    w_state = ST_FETCH;
                    w_addr  = '0;
                    w_done  = 1'b0;
                    w_error = 1'b0;
                    w_retry = '0;
                    w_busy  = 1'b1;
                end
            end
            ST_FETCH:    w_state = ST_WAIT_ROM;
            ST_WAIT_ROM: w_state = ST_DECODE;
            ST_DECODE: begin
                if (i_rom_dout == OV7670_ROM_END) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else if (i_rom_dout == OV7670_ROM_DELAY) begin
                    w_state = ST_DELAY;
                    w_dly   = C_DLY_LOAD;
                end else begin
                    w_state = ST_SEND;
                    w_reg   = i_rom_dout[15:8];
                    w_val   = i_rom_dout[7:0];
                    w_valid = 1'b1;
                end
            end
            ST_SEND: begin
                if (i_cmd_ready) begin
                    w_valid = 1'b0;
                    w_state = ST_WAIT_XFER;
                end
            end
            ST_WAIT_XFER: begin
                if (i_xfer_done) begin
                    if (!i_xfer_nack) begin
                        w_advance = 1'b1;
                    end else if (r_retry < C_MAX_RETRY) begin
                        w_retry = r_retry + 1'b1;
                        w_valid = 1'b1;
                        w_state = ST_SEND;
                    end else begin
                        w_state    = ST_ERROR;
                        w_error    = 1'b1;
                        w_busy     = 1'b0;
                        w_err_addr = r_addr;
                    end
                end
            end
            ST_DELAY: begin
                if (r_dly == '0) begin
                    w_advance = 1'b1;
                end else begin
                    w_dly = r_dly - 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // The last ROM address ends the sequence rather than wrapping
        if (w_advance) begin
            w_retry = '0;
            if (r_addr == C_LAST_ADDR) begin
                w_state = ST_DONE;
                w_done  = 1'b1;
                w_busy  = 1'b0;
            end else begin
                w_addr  = r_addr + 1'b1;
                w_state = ST_FETCH;
            end
        end
    end

    assign o_rom_addr  = r_addr;
    assign o_cmd_valid = r_valid;
    assign o_cmd_reg   = r_reg;
    assign o_cmd_val   = r_val;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_config_sequencer
//  Description : Self-checking bench: 1-clk ROM model, SCCB master BFM with
//                programmable stall/NACK, and an entry-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_config_sequencer;

    localparam int AW    = 3;
    localparam int NENT  = 8;
    localparam int DLY   = 20;
    localparam int MAXR  = 3;
    localparam int LAT   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] o_rom_addr;
    logic [15:0]   i_rom_dout = 16'h0;
    logic          o_cmd_valid;
    logic          i_cmd_ready;
    logic [7:0]    o_cmd_reg, o_cmd_val;
    logic          i_xfer_done, i_xfer_nack;
    logic          o_busy, o_done, o_error;
    logic [AW-1:0] o_err_addr;

    ov7670_config_sequencer #(.ROM_AW(AW), .DELAY_CYCLES(DLY), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_rom_addr(o_rom_addr),
        .i_rom_dout(i_rom_dout), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
        .o_cmd_reg(o_cmd_reg), .o_cmd_val(o_cmd_val), .i_xfer_done(i_xfer_done),
        .i_xfer_nack(i_xfer_nack), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_addr(o_err_addr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents and per-entry number of NACKs the BFM answers before ACKing
    logic [15:0] rom [NENT];
    int          nack_cnt [NENT];
    int          attempts [NENT];

    // Registered-read ROM, one clock of latency
    always @(posedge clk) i_rom_dout <= rom[o_rom_addr];

    // BFM observations
    logic [18:0] got_q [$];
    int          rise_q [$];
    int          xd_q [$];
    int          stall_len = 0;
    int          instab = 0;
    int          start_cyc = 0;

    // SCCB master BFM: stalls ready, records accepted writes, answers ACK/NACK
    initial begin
        int          busy_cnt = 0;
        int          stall_left = 0;
        bit          seen = 0;
        bit          cur_nack = 0;
        bit          prev_valid = 0;
        logic [15:0] cap = '0;
        logic [AW-1:0] a;
        i_cmd_ready = 1'b0;
        i_xfer_done = 1'b0;
        i_xfer_nack = 1'b0;
        forever begin
            @(negedge clk);
            i_xfer_done = 1'b0;
            i_xfer_nack = 1'b0;
            i_cmd_ready = 1'b0;
            if (o_cmd_valid === 1'b1 && !prev_valid) rise_q.push_back(cyc);
            prev_valid = (o_cmd_valid === 1'b1);
            if (!rst_n) begin
                busy_cnt = 0;
                seen     = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    i_xfer_done = 1'b1;
                    i_xfer_nack = cur_nack;
                    xd_q.push_back(cyc);
                end
            end else if (o_cmd_valid === 1'b1) begin
                if (!seen) begin
                    seen       = 1;
                    stall_left = stall_len;
                    cap        = {o_cmd_reg, o_cmd_val};
                end else if ({o_cmd_reg, o_cmd_val} !== cap) begin
                    instab++;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    i_cmd_ready = 1'b1;
                    a = o_rom_addr;
                    got_q.push_back({a, o_cmd_reg, o_cmd_val});
                    cur_nack = (attempts[a] < nack_cnt[a]);
                    attempts[a]++;
                    busy_cnt = LAT;
                    seen     = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the entry list by the sequencing rules
    logic [18:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_eaddr, exp_final;

    task automatic model();
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_eaddr = 0; exp_final = 0;
        for (int a = 0; a < NENT; a++) begin
            exp_final = a;
            if (rom[a] == 16'hFFFF) begin
                exp_done = 1;
                return;
            end
            if (rom[a] != 16'hFFF0) begin
                int n;
                n = (nack_cnt[a] > MAXR) ? MAXR + 1 : nack_cnt[a] + 1;
                for (int k = 0; k < n; k++) exp_q.push_back({a[AW-1:0], rom[a]});
                if (nack_cnt[a] > MAXR) begin
                    exp_err   = 1;
                    exp_eaddr = a;
                    return;
                end
            end
        end
        exp_done = 1;
    endtask

    task automatic clear_cfg();
        for (int a = 0; a < NENT; a++) begin
            rom[a] = 16'hFFFF;
            nack_cnt[a] = 0;
        end
    endtask

    // Start one sequence, wait (bounded) for completion and compare with the model
    task automatic run_seq(input string tag, input int stall, input bit extra_start);
        int n;
        got_q.delete(); rise_q.delete(); xd_q.delete();
        for (int a = 0; a < NENT; a++) attempts[a] = 0;
        stall_len = stall;
        instab    = 0;
        @(negedge clk);
        i_start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        i_start = 1'b0;
        if (extra_start) begin
            repeat (2) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        for (int i = 0; i < 4000 && !(o_done === 1'b1 || o_error === 1'b1); i++) @(negedge clk);
        chk({tag, "_finished"}, 32'(o_done | o_error), 32'd1);
        repeat (20) @(negedge clk);
        model();
        chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_done"},     32'(o_done),     32'(exp_done));
        chk({tag, "_error"},    32'(o_error),    32'(exp_err));
        if (exp_err) chk({tag, "_err_addr"}, 32'(o_err_addr), 32'(exp_eaddr));
        chk({tag, "_rom_addr"}, 32'(o_rom_addr), 32'(exp_final));
        chk({tag, "_busy"},     32'(o_busy),     32'd0);
        chk({tag, "_cmd_valid"},32'(o_cmd_valid),32'd0);
        chk({tag, "_stable"},   32'(instab),     32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_addr"},  32'(o_rom_addr),  32'd0);
        chk({tag, "_cmd_valid"}, 32'(o_cmd_valid), 32'd0);
        chk({tag, "_cmd_regval"},32'({o_cmd_reg, o_cmd_val}), 32'd0);
        chk({tag, "_flags"},     32'({o_busy, o_done, o_error}), 32'd0);
        chk({tag, "_err_addr"},  32'(o_err_addr),  32'd0);
    endtask

    initial begin
        clear_cfg();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: two writes then end marker
        clear_cfg();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run_seq("basic", 0, 0);
        // start sampled one clock after it is driven, then 3 clocks to cmd_valid
        chk("start_latency", 32'(rise_q.size() > 0 ? rise_q[0] - start_cyc : -1), 32'd4);

        // 2: delay marker between writes: delay entry's 3-clock fetch/decode,
        //    DELAY clocks in the wait, then the next entry's 3-clock fetch/decode
        clear_cfg();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101;
        run_seq("delay", 0, 0);
        chk("delay_latency",
            32'((rise_q.size() > 1 && xd_q.size() > 0) ? rise_q[1] - xd_q[0] : -1),
            32'(1 + 3 + DLY + 3));

        // 3: NACK twice then ACK; then NACK forever
        clear_cfg();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        nack_cnt[1] = 2;
        run_seq("retry_ok", 0, 0);
        nack_cnt[1] = 100;
        run_seq("retry_fail", 0, 0);

        // 4: long ready stall on every write
        clear_cfg();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        run_seq("stall50", 50, 0);

        // 5: no end marker, includes a non-marker FFxx write
        for (int a = 0; a < NENT; a++) begin
            rom[a] = {8'(a + 8'h10), 8'(a * 3)};
            nack_cnt[a] = 0;
        end
        rom[4] = 16'hFF12;
        run_seq("full_rom", 0, 0);

        // 6: reset during DELAY, then restart with a start pulse while busy
        clear_cfg();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 200 && xd_q.size() == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("in_delay_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");
        run_seq("restart", 0, 1);

        // 7: randomized ROM contents, NACK counts and stalls
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < NENT; a++) begin
                int r;
                r = $urandom_range(0, 11);
                rom[a] = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFF0 : 16'($urandom);
                nack_cnt[a] = $urandom_range(0, 4);
            end
            run_seq("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
